// File: rtl/pwm_pkg.sv
// Register map and reset helpers for the multi-channel PWM engine.
package pwm_pkg;

  localparam int unsigned ADDR_EN_OUT    = 'h00;
  localparam int unsigned ADDR_EN_PWM    = 'h04;
  localparam int unsigned ADDR_POL       = 'h08;
  localparam int unsigned ADDR_PRESCALE  = 'h0C;
  localparam int unsigned ADDR_PERIOD    = 'h0D;
  localparam int unsigned ADDR_SYNC      = 'h0E;
  localparam int unsigned ADDR_DUTY_BASE = 'h10;

  localparam int unsigned CNT_W_DEFAULT = 8;

  // Reset period is the full counter range for a given counter width.
  function automatic int unsigned period_rst(int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

  localparam int unsigned PERIOD_RST = period_rst(CNT_W_DEFAULT);

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler, period counter and period shadow; flags shadow loads at wrap or resync.
module pwm_timebase import pwm_pkg::*; #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] prescale,
  input  logic [CNT_W-1:0] period,
  input  logic             sync,
  output logic [CNT_W-1:0] cnt,
  output logic             load,
  output logic             period_start
);

  localparam logic [CNT_W-1:0] PeriodRst = CNT_W'(period_rst(CNT_W));

  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic             tick, wrap, load_q;

  always_comb begin
    // >= rather than == so lowering prescale mid-count cannot strand the prescaler.
    tick         = (pre_cnt_q >= prescale);
    wrap         = tick && (cnt_q >= period_act_q);
    load         = sync || wrap;
    pre_cnt_d    = (sync || tick) ? '0 : pre_cnt_q + 1'b1;
    cnt_d        = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
    period_act_d = load ? period : period_act_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q    <= '0;
      cnt_q        <= '0;
      period_act_q <= PeriodRst;
      load_q       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      cnt_q        <= cnt_d;
      period_act_q <= period_act_d;
      load_q       <= load;
      // Delayed once more so the pulse lines up with the first registered output of the period.
      period_start <= load_q;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM engine: register file, per-channel duty shadows and registered output stage.
module pwm_multi_channel import pwm_pkg::*; #(
  parameter int unsigned N_CH   = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic [N_CH-1:0]   pwm_out,
  output logic              period_start
);

  localparam logic [CNT_W-1:0] PeriodRst = CNT_W'(period_rst(CNT_W));

  logic [N_CH-1:0]            en_out_q, en_out_d;
  logic [N_CH-1:0]            en_pwm_q, en_pwm_d;
  logic [N_CH-1:0]            pol_q, pol_d;
  logic [CNT_W-1:0]           prescale_q, prescale_d;
  logic [CNT_W-1:0]           period_q, period_d;
  logic [N_CH-1:0][CNT_W-1:0] duty_q, duty_d;

  logic             sync, load;
  logic [CNT_W-1:0] cnt;
  logic [N_CH-1:0]  raw, pwm_d;

  assign sync = wr_en && (wr_addr == ADDR_W'(ADDR_SYNC));

  always_comb begin
    en_out_d   = en_out_q;
    en_pwm_d   = en_pwm_q;
    pol_d      = pol_q;
    prescale_d = prescale_q;
    period_d   = period_q;
    duty_d     = duty_q;
    if (wr_en) begin
      // Looping over real channels means bits past N_CH are never stored.
      for (int ch = 0; ch < int'(N_CH); ch++) begin
        if (wr_addr == ADDR_W'(ADDR_EN_OUT + ch / 8)) en_out_d[ch] = wr_data[3'(ch % 8)];
        if (wr_addr == ADDR_W'(ADDR_EN_PWM + ch / 8)) en_pwm_d[ch] = wr_data[3'(ch % 8)];
        if (wr_addr == ADDR_W'(ADDR_POL + ch / 8))    pol_d[ch]    = wr_data[3'(ch % 8)];
        if (wr_addr == ADDR_W'(ADDR_DUTY_BASE + ch))  duty_d[ch]   = wr_data[CNT_W-1:0];
      end
      if (wr_addr == ADDR_W'(ADDR_PRESCALE)) prescale_d = wr_data[CNT_W-1:0];
      if (wr_addr == ADDR_W'(ADDR_PERIOD))   period_d   = wr_data[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_out_q   <= '0;
      en_pwm_q   <= '0;
      pol_q      <= '0;
      prescale_q <= '0;
      period_q   <= PeriodRst;
      duty_q     <= '0;
    end else begin
      en_out_q   <= en_out_d;
      en_pwm_q   <= en_pwm_d;
      pol_q      <= pol_d;
      prescale_q <= prescale_d;
      period_q   <= period_d;
      duty_q     <= duty_d;
    end
  end

  pwm_timebase #(
    .CNT_W (CNT_W)
  ) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .prescale     (prescale_q),
    .period       (period_q),
    .sync         (sync),
    .cnt          (cnt),
    .load         (load),
    .period_start (period_start)
  );

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] duty_act;

    // Shadow samples the pre-write register, so a write on the wrap edge waits a period.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        duty_act <= '0;
      end else if (load) begin
        duty_act <= duty_q[ch];
      end
    end

    assign raw[ch] = (cnt < duty_act);
  end

  always_comb begin
    pwm_d = en_out_q & (((raw & en_pwm_q) | ~en_pwm_q) ^ pol_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= pwm_d;
    end
  end

endmodule
